// File: rtl/add_acc_pkg.sv
// Shared op codes and flag type for the pipelined add/accumulate block.
package add_acc_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD  = 2'b00;
    localparam op_t OP_SUB  = 2'b01;
    localparam op_t OP_ACC  = 2'b10;
    localparam op_t OP_LOAD = 2'b11;

    typedef struct packed {
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/add_acc_pipe_if.sv
// Operand/result bus of add_acc_pipe; master drives operands, slave returns results.
interface add_acc_pipe_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic [W-1:0]     result;
    logic             carry;
    logic             overflow;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, op, a, b,
        input  out_valid, result, carry, overflow, acc, op_count
    );

    modport slave (
        input  in_valid, op, a, b,
        output out_valid, result, carry, overflow, acc, op_count
    );
endinterface

// File: rtl/add_sat_core.sv
// Combinational W-bit add/subtract with carry/borrow, signed overflow and optional
// unsigned saturation. Flags always describe the raw, unsaturated operation.
module add_sat_core #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    input  logic         sat,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         overflow
);

    logic [W:0] raw;
    logic       sign_ovf;

    assign raw   = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    assign carry = raw[W];

    assign sign_ovf = (raw[W-1] != x[W-1]);
    assign overflow = sub ? ((x[W-1] != y[W-1]) && sign_ovf)
                          : ((x[W-1] == y[W-1]) && sign_ovf);

    // A borrow clamps to zero, a carry clamps to all ones.
    assign result = (sat && carry) ? (sub ? '0 : '1) : raw[W-1:0];

endmodule

// File: rtl/add_acc_pipe.sv
// Two-stage add/sub/accumulate/load pipeline: S1 registers operands, S2 computes,
// updates the accumulator and counts completed operations.
module add_acc_pipe
    import add_acc_pkg::*;
#(
    parameter int W     = 4,
    parameter bit SAT   = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    add_acc_pipe_if.slave bus
);

    logic             s1_valid_q;
    op_t              s1_op_q;
    logic [W-1:0]     s1_a_q;
    logic [W-1:0]     s1_b_q;

    logic             out_valid_q;
    logic [W-1:0]     result_q, result_d;
    flags_t           flags_q, flags_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q;

    logic [W-1:0]     core_x, core_y, core_result;
    logic             core_sub, core_carry, core_overflow;

    // ACC reuses the adder with the accumulator as the first operand.
    always_comb begin
        core_x   = s1_a_q;
        core_y   = s1_b_q;
        core_sub = 1'b0;
        case (s1_op_q)
            OP_SUB: core_sub = 1'b1;
            OP_ACC: begin
                core_x = acc_q;
                core_y = s1_a_q;
            end
            default: ;
        endcase
    end

    add_sat_core #(.W(W)) u_core (
        .x        (core_x),
        .y        (core_y),
        .sub      (core_sub),
        .sat      (SAT),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow)
    );

    // NOTE: every output gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        if (s1_valid_q) begin
            if (s1_op_q == OP_LOAD) begin
                result_d = s1_a_q;
                flags_d  = '0;
                acc_d    = s1_a_q;
            end else begin
                result_d         = core_result;
                flags_d.carry    = core_carry;
                flags_d.overflow = core_overflow;
                if (s1_op_q == OP_ACC) acc_d = core_result;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_q <= bus.op;
                s1_a_q  <= bus.a;
                s1_b_q  <= bus.b;
            end
            out_valid_q <= s1_valid_q;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            if (s1_valid_q) op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = flags_q.carry;
    assign bus.overflow  = flags_q.overflow;
    assign bus.acc       = acc_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_add_acc_pipe.sv
// Directed bench for add_acc_pipe: a wrapping (SAT=0) and a saturating (SAT=1)
// instance receive identical stimulus and are checked against hand-computed values.
module tb_add_acc_pipe;
    import add_acc_pkg::*;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    add_acc_pipe_if #(.W(W), .CNT_W(CNT_W)) bus_w ();
    add_acc_pipe_if #(.W(W), .CNT_W(CNT_W)) bus_s ();

    add_acc_pipe #(.W(W), .SAT(1'b0), .CNT_W(CNT_W)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    add_acc_pipe #(.W(W), .SAT(1'b1), .CNT_W(CNT_W)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus_w.in_valid = v;
        bus_w.op       = op;
        bus_w.a        = a;
        bus_w.b        = b;
        bus_s.in_valid = v;
        bus_s.op       = op;
        bus_s.a        = a;
        bus_s.b        = b;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, '0, '0);
    endtask

    int high_cnt;
    int gaps;
    logic prev_ov;

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", bus_w.out_valid, 0);
        check("rst_result",    bus_w.result,    0);
        check("rst_carry",     bus_w.carry,     0);
        check("rst_overflow",  bus_w.overflow,  0);
        check("rst_acc",       bus_w.acc,       0);
        check("rst_op_count",  bus_w.op_count,  0);

        // ADD 7+5: two-edge latency, signed overflow, single-cycle pulse
        drive(1'b1, OP_ADD, 4'd7, 4'd5);
        tick();
        idle();
        check("add_not_early", bus_w.out_valid, 0);
        tick();
        check("add_valid",    bus_w.out_valid, 1);
        check("add_result",   bus_w.result,    12);
        check("add_carry",    bus_w.carry,     0);
        check("add_overflow", bus_w.overflow,  1);
        check("add_op_count", bus_w.op_count,  1);
        tick();
        check("add_pulse_end",   bus_w.out_valid, 0);
        check("add_result_hold", bus_w.result,    12);
        check("add_acc_untouch", bus_w.acc,       0);

        // SUB 3-5: borrow, wrap vs saturate to zero
        drive(1'b1, OP_SUB, 4'd3, 4'd5);
        tick();
        idle();
        tick();
        check("sub_result",     bus_w.result,   14);
        check("sub_borrow",     bus_w.carry,    1);
        check("sub_overflow",   bus_w.overflow, 0);
        check("sub_sat_result", bus_s.result,   0);
        check("sub_sat_borrow", bus_s.carry,    1);

        // Back-to-back LOAD 9, ACC 4, ACC 6
        drive(1'b1, OP_LOAD, 4'd9, 4'd15);
        tick();
        drive(1'b1, OP_ACC, 4'd4, 4'd15);
        tick();
        check("load_valid",  bus_w.out_valid, 1);
        check("load_result", bus_w.result,    9);
        check("load_carry",  bus_w.carry,     0);
        check("load_acc",    bus_w.acc,       9);
        drive(1'b1, OP_ACC, 4'd6, 4'd15);
        tick();
        idle();
        check("acc1_result", bus_w.result, 13);
        check("acc1_carry",  bus_w.carry,  0);
        check("acc1_acc",    bus_w.acc,    13);
        tick();
        check("acc2_valid",    bus_w.out_valid, 1);
        check("acc2_result",   bus_w.result,    3);
        check("acc2_carry",    bus_w.carry,     1);
        check("acc2_overflow", bus_w.overflow,  0);
        check("acc2_acc",      bus_w.acc,       3);
        check("acc2_sat_res",  bus_s.result,    15);
        check("acc2_sat_acc",  bus_s.acc,       15);
        check("acc2_op_count", bus_w.op_count,  5);
        tick();
        check("acc2_pulse_end", bus_w.out_valid, 0);
        check("acc2_acc_hold",  bus_w.acc,       3);

        // Saturating accumulate: LOAD 14, ACC 5, ACC 0
        drive(1'b1, OP_LOAD, 4'd14, 4'd0);
        tick();
        drive(1'b1, OP_ACC, 4'd5, 4'd9);
        tick();
        drive(1'b1, OP_ACC, 4'd0, 4'd9);
        tick();
        idle();
        check("sat_acc_result",   bus_s.result,   15);
        check("sat_acc_carry",    bus_s.carry,    1);
        check("sat_acc_overflow", bus_s.overflow, 0);
        check("sat_acc_acc",      bus_s.acc,      15);
        check("wrap_acc_result",  bus_w.result,   3);
        check("wrap_acc_acc",     bus_w.acc,      3);
        tick();
        check("sat_acc0_result", bus_s.result, 15);
        check("sat_acc0_carry",  bus_s.carry,  0);
        check("sat_acc0_acc",    bus_s.acc,    15);
        check("wrap_acc0_result", bus_w.result, 3);
        tick();

        // Reset with two ops in flight; reset also wins over in_valid
        drive(1'b1, OP_ADD, 4'd9, 4'd9);
        tick();
        drive(1'b1, OP_ADD, 4'd2, 4'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("flush_valid0",   bus_w.out_valid, 0);
        check("flush_result",   bus_w.result,    0);
        check("flush_carry",    bus_w.carry,     0);
        check("flush_overflow", bus_w.overflow,  0);
        check("flush_acc",      bus_w.acc,       0);
        check("flush_sat_acc",  bus_s.acc,       0);
        tick();
        check("flush_valid1", bus_w.out_valid, 0);
        tick();
        check("flush_valid2",   bus_w.out_valid, 0);
        check("flush_op_count", bus_w.op_count,  0);

        // Stream 257 ADDs with in_valid held high; op_count wraps to 1
        high_cnt = 0;
        gaps     = 0;
        prev_ov  = 1'b0;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            drive(1'b1, OP_ADD, iv[3:0], 4'd1);
            tick();
            if (bus_w.out_valid) begin
                if (high_cnt > 0 && !prev_ov) gaps++;
                high_cnt++;
            end
            prev_ov = bus_w.out_valid;
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_w.out_valid) begin
                if (high_cnt > 0 && !prev_ov) gaps++;
                high_cnt++;
            end
            prev_ov = bus_w.out_valid;
        end
        check("stream_high_cycles", high_cnt,        257);
        check("stream_gaps",        gaps,            0);
        check("stream_op_count",    bus_w.op_count,  1);
        check("stream_last_result", bus_w.result,    1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
